// File: rtl/alu_pkg.sv
// Shared definitions for the chunked adder/subtractor:
//   state_t  - FSM state encoding (IDLE / RUN / DONE)
//   OP_ADD / OP_SUB - encoding of the op input
//   flags_t  - registered status flag bundle
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic carry;
        logic sign;
        logic zero;
        logic parity;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Ports:
//   cin  - carry into bit 0
//   a, b - CHUNK-bit addends
//   s    - CHUNK-bit sum
//   cout - carry out of the top bit
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic             cin,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
            assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[CHUNK];

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor. A WIDTH-bit operand pair is processed CHUNK
// bits per clock through one shared chunk_adder; the inter-chunk carry lives
// in a register. Result and flags are registered when the last chunk is done.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid / in_ready  - operand handshake (in_ready only in IDLE)
//   x, y, op             - operands; op 0 = x+y, 1 = x-y
//   out_valid / out_ready- result handshake (out_valid only in DONE)
//   z                    - result
//   carry, sign, zero, parity, overflow - status flags
module chunked_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             sign,
    output logic             zero,
    output logic             parity,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] yeff_reg;
    logic [WIDTH-1:0] z_acc_reg;
    logic [WIDTH-1:0] z_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    flags_t           flags_reg;

    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             cout_chunk;
    logic [WIDTH-1:0] z_full;
    logic             is_last;
    logic             accept;
    flags_t           flags_next;
    int               idx;

    // in_ready is gated by rst so it reads 0 for the whole reset cycle,
    // even though state is already IDLE.
    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE);
    assign accept    = in_valid && in_ready;
    assign is_last   = (cnt_reg == CW'(N - 1));

    always_comb begin
        idx     = int'(cnt_reg) * CHUNK;
        a_chunk = x_reg[idx +: CHUNK];
        b_chunk = yeff_reg[idx +: CHUNK];
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .cin  (carry_reg),
        .a    (a_chunk),
        .b    (b_chunk),
        .s    (s_chunk),
        .cout (cout_chunk)
    );

    // Complete result as it will look once the current chunk is written;
    // flags on the final edge are derived from this rather than z_acc_reg.
    always_comb begin
        z_full              = z_acc_reg;
        z_full[idx +: CHUNK] = s_chunk;
        flags_next.carry    = cout_chunk;
        flags_next.sign     = z_full[WIDTH-1];
        flags_next.zero     = ~|z_full;
        flags_next.parity   = ~^z_full;
        flags_next.overflow = (x_reg[WIDTH-1] == yeff_reg[WIDTH-1]) &&
                              (z_full[WIDTH-1] != x_reg[WIDTH-1]);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (is_last)   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            yeff_reg  <= '0;
            z_acc_reg <= '0;
            z_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            flags_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && accept) begin
                x_reg     <= x;
                yeff_reg  <= (op == OP_SUB) ? ~y : y;
                carry_reg <= (op == OP_SUB);
                cnt_reg   <= '0;
            end else if (state_reg == RUN) begin
                z_acc_reg <= z_full;
                carry_reg <= cout_chunk;
                cnt_reg   <= cnt_reg + 1'b1;
                if (is_last) begin
                    z_reg     <= z_full;
                    flags_reg <= flags_next;
                end
            end
        end
    end

    assign z        = z_reg;
    assign carry    = flags_reg.carry;
    assign sign     = flags_reg.sign;
    assign zero     = flags_reg.zero;
    assign parity   = flags_reg.parity;
    assign overflow = flags_reg.overflow;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed bench for chunked_add_sub: a 16/4 instance for the main scenarios
// and an 8/8 instance for the single-chunk case.
module tb_chunked_add_sub;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-bit, 4-bit chunks
    logic        in_valid16 = 1'b0, out_ready16 = 1'b0, op16 = 1'b0;
    logic [15:0] x16 = '0, y16 = '0, z16;
    logic        in_ready16, out_valid16;
    logic        c16, s16, zr16, p16, v16;

    // 8-bit, single chunk
    logic        in_valid8 = 1'b0, out_ready8 = 1'b0, op8 = 1'b0;
    logic [7:0]  x8 = '0, y8 = '0, z8;
    logic        in_ready8, out_valid8;
    logic        c8, s8, zr8, p8, v8;

    chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .x(x16), .y(y16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
        .z(z16), .carry(c16), .sign(s16), .zero(zr16), .parity(p16), .overflow(v16)
    );

    chunked_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .x(x8), .y(y8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .z(z8), .carry(c8), .sign(s8), .zero(zr8), .parity(p8), .overflow(v8)
    );

    int errors = 0;
    int checks = 0;

    // Acceptance monitor for the 16-bit instance
    int cyc = 0;
    int acc_count = 0;
    int acc_cyc_q[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid16 && in_ready16) begin
            acc_count <= acc_count + 1;
            acc_cyc_q.push_back(cyc);
        end
    end

    // Drives one 16-bit op, returns edges from acceptance to out_valid.
    // Leaves the DUT in DONE with out_ready low.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic o,
                          output int lat, output bit timeout);
        timeout = 1'b0;
        lat = 0;
        @(negedge clk);
        x16 = a; y16 = b; op16 = o; in_valid16 = 1'b1;
        for (int i = 0; i < 30 && !in_ready16; i++) @(negedge clk);
        if (!in_ready16) begin
            timeout = 1'b1;
            in_valid16 = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        x16 = ~a; y16 = ~b; op16 = ~o;   // latched copies must be used
        while (!out_valid16 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid16) timeout = 1'b1;
    endtask

    task automatic release16();
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (in_ready16 !== 1'b0 || out_valid16 !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 0 0", in_ready16, out_valid16);
        end
        checks++;
        if ({z16, c16, s16, zr16, p16, v16} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: z=%h flags=%b%b%b%b%b, required 0000 00000",
                     z16, c16, s16, zr16, p16, v16);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready16 !== 1'b1 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready16=%b in_ready8=%b, required 1 1", in_ready16, in_ready8);
        end
        $display("test_reset done");
    endtask

    task automatic test_add_overflow();
        int lat; bit to;
        send16(16'h7FFF, 16'h0001, OP_ADD, lat, to);
        checks++;
        if (to || lat != 4) begin
            errors++;
            $display("FAIL add_ovf_latency: lat=%0d timeout=%0b, required 4", lat, to);
        end
        checks++;
        if (z16 !== 16'h8000 || {c16, s16, zr16, p16, v16} !== 5'b01001) begin
            errors++;
            $display("FAIL add_ovf_result: z=%h csZpv=%b%b%b%b%b, required 8000 01001",
                     z16, c16, s16, zr16, p16, v16);
        end
        checks++;
        if (in_ready16 !== 1'b0) begin
            errors++;
            $display("FAIL add_ovf_ready_in_done: in_ready=%b, required 0", in_ready16);
        end
        $display("add 7FFF+0001 -> z=%h lat=%0d", z16, lat);
        release16();
    endtask

    task automatic test_add_carry_zero();
        int lat; bit to;
        send16(16'hFFFF, 16'h0001, OP_ADD, lat, to);
        checks++;
        if (to || z16 !== 16'h0000 || {c16, s16, zr16, p16, v16} !== 5'b10110) begin
            errors++;
            $display("FAIL add_carry_zero: z=%h csZpv=%b%b%b%b%b timeout=%0b, required 0000 10110",
                     z16, c16, s16, zr16, p16, v16, to);
        end
        $display("add FFFF+0001 -> z=%h", z16);
        release16();
    endtask

    task automatic test_sub_borrow();
        int lat; bit to;
        send16(16'h0005, 16'h0007, OP_SUB, lat, to);
        checks++;
        if (to || z16 !== 16'hFFFE || {c16, s16, zr16, p16, v16} !== 5'b01000) begin
            errors++;
            $display("FAIL sub_borrow: z=%h csZpv=%b%b%b%b%b timeout=%0b, required FFFE 01000",
                     z16, c16, s16, zr16, p16, v16, to);
        end
        $display("sub 0005-0007 -> z=%h", z16);
        release16();
    endtask

    task automatic test_sub_overflow();
        int lat; bit to;
        int base;
        int gap;
        send16(16'h8000, 16'h0001, OP_SUB, lat, to);
        checks++;
        if (to || z16 !== 16'h7FFF || {c16, s16, zr16, p16, v16} !== 5'b10001) begin
            errors++;
            $display("FAIL sub_ovf: z=%h csZpv=%b%b%b%b%b timeout=%0b, required 7FFF 10001",
                     z16, c16, s16, zr16, p16, v16, to);
        end
        release16();
        // Back-to-back stream with both sides always willing
        @(negedge clk);
        base = acc_cyc_q.size();
        x16 = 16'h8000; y16 = 16'h0001; op16 = OP_SUB;
        in_valid16 = 1'b1; out_ready16 = 1'b1;
        for (int i = 0; i < 40 && acc_cyc_q.size() < base + 2; i++) @(negedge clk);
        in_valid16 = 1'b0;
        gap = (acc_cyc_q.size() >= base + 2) ? acc_cyc_q[base+1] - acc_cyc_q[base] : -1;
        checks++;
        if (gap != 6) begin
            errors++;
            $display("FAIL issue_interval: gap=%0d cycles, required 6", gap);
        end
        // drain the second op
        for (int i = 0; i < 20 && (out_valid16 || !in_ready16); i++) @(negedge clk);
        out_ready16 = 1'b0;
        $display("sub 8000-0001 -> z=%h issue gap=%0d", z16, gap);
    endtask

    task automatic test_back_to_back_stall();
        int lat; bit to;
        int acc0;
        send16(16'h1234, 16'h1111, OP_ADD, lat, to);
        checks++;
        if (to || z16 !== 16'h2345 || {c16, s16, zr16, p16, v16} !== 5'b00010) begin
            errors++;
            $display("FAIL stall_first: z=%h csZpv=%b%b%b%b%b, required 2345 00010",
                     z16, c16, s16, zr16, p16, v16);
        end
        acc0 = acc_count;
        x16 = 16'h0001; y16 = 16'h0002; op16 = OP_ADD; in_valid16 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (z16 !== 16'h2345 || {c16, s16, zr16, p16, v16} !== 5'b00010 ||
                in_ready16 !== 1'b0 || out_valid16 !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: z=%h flags=%b%b%b%b%b in_ready=%b out_valid=%b, required 2345 00010 0 1",
                         i, z16, c16, s16, zr16, p16, v16, in_ready16, out_valid16);
            end
        end
        checks++;
        if (acc_count != acc0) begin
            errors++;
            $display("FAIL stall_no_accept: accepts=%0d, required %0d", acc_count, acc0);
        end
        release16();
        checks++;
        if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle: in_ready=%b out_valid=%b, required 1 0", in_ready16, out_valid16);
        end
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (acc_count != acc0 + 1 || lat != 4 || z16 !== 16'h0003) begin
            errors++;
            $display("FAIL stall_second: accepts=%0d lat=%0d z=%h, required %0d 4 0003",
                     acc_count, lat, z16, acc0 + 1);
        end
        $display("stall then 0001+0002 -> z=%h lat=%0d", z16, lat);
        release16();
    endtask

    task automatic test_reset_mid_run();
        int lat; bit to;
        @(negedge clk);
        x16 = 16'h4444; y16 = 16'h1111; op16 = OP_ADD; in_valid16 = 1'b1;
        for (int i = 0; i < 30 && !in_ready16; i++) @(negedge clk);
        @(posedge clk); #1;           // acceptance edge
        in_valid16 = 1'b0;
        @(posedge clk); #1;           // now in 2nd RUN cycle
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid16 !== 1'b0 || z16 !== 16'h0000 || in_ready16 !== 1'b1 || zr16 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: out_valid=%b z=%h in_ready=%b zero=%b, required 0 0000 1 0",
                     out_valid16, z16, in_ready16, zr16);
        end
        send16(16'h0F0F, 16'h00F1, OP_ADD, lat, to);
        checks++;
        if (to || lat != 4 || z16 !== 16'h1000 || {c16, s16, zr16, p16, v16} !== 5'b00000) begin
            errors++;
            $display("FAIL after_reset_op: z=%h csZpv=%b%b%b%b%b lat=%0d, required 1000 00000 4",
                     z16, c16, s16, zr16, p16, v16, lat);
        end
        $display("reset mid-run, then 0F0F+00F1 -> z=%h", z16);
        release16();
    endtask

    task automatic test_degenerate();
        int lat;
        @(negedge clk);
        x8 = 8'h80; y8 = 8'h80; op8 = OP_ADD; in_valid8 = 1'b1;
        for (int i = 0; i < 30 && !in_ready8; i++) @(negedge clk);
        @(posedge clk); #1;
        in_valid8 = 1'b0; x8 = 8'h00; y8 = 8'h00;
        lat = 0;
        while (!out_valid8 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 1 || z8 !== 8'h00 || {c8, s8, zr8, p8, v8} !== 5'b10111) begin
            errors++;
            $display("FAIL degenerate_8x8: z=%h csZpv=%b%b%b%b%b lat=%0d, required 00 10111 1",
                     z8, c8, s8, zr8, p8, v8, lat);
        end
        $display("8/8 add 80+80 -> z=%h lat=%0d", z8, lat);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL degenerate_release: in_ready=%b out_valid=%b, required 1 0", in_ready8, out_valid8);
        end
    endtask

    // Handshake exclusivity checked every cycle once out of reset
    always @(negedge clk) begin
        if (!rst && in_ready16 && out_valid16) begin
            errors++;
            $display("FAIL ready_valid_overlap: both high at cycle %0d", cyc);
        end
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_add_carry_zero();
        test_sub_borrow();
        test_sub_overflow();
        test_back_to_back_stall();
        test_reset_mid_run();
        test_degenerate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
